// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 16-bit breadboard ALU: owns the 32-bit accumulator, drives the
// external combinational ALU, and runs signed div/mod on an internal restoring divider.
module alu_cmd_sequencer #(
    parameter int DATA_W = 16,
    parameter int RES_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [RES_W-1:0]  alu_result,
    input  logic              alu_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [1:0]        res_err,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam int EXT_W = RES_W - DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_NAND,
        OP_NOR, OP_XOR, OP_XNOR, OP_NOT, OP_ONES, OP_CLEAR, OP_NOP, OP_ILLEGAL
    } op_t;

    state_t              state_q, state_d;
    logic [RES_W-1:0]    acc_q;
    logic [DATA_W-1:0]   a_q, b_q;
    op_t                 op_q;
    logic [1:0]          err_q;

    // Divider: quo_q starts as |A| and shifts out dividend bits while shifting in quotient bits.
    logic [DATA_W-1:0]   quo_q, dvs_q, rem_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                cmd_is_div, b_is_zero, div_last, ovf_err;
    logic [DATA_W:0]     rem_shift, rem_trial;
    logic                take;
    logic [RES_W-1:0]    exec_result;
    logic [RES_W-1:0]    quo_ext, rem_ext, quo_signed, rem_signed;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
    endfunction

    assign cmd_is_div = (cmd_op == OP_DIV) || (cmd_op == OP_MOD);
    assign b_is_zero  = (acc_q[DATA_W-1:0] == '0);
    assign div_last   = (cnt_q == CNT_W'(DATA_W - 1));
    assign ovf_err    = alu_ovf && ((op_q == OP_ADD) || (op_q == OP_SUB));

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign res_data = acc_q;
    assign res_err  = err_q;

    // NOTE: every sequential block uses non-blocking assignments so all registers update
    // from the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each output of this block gets a default before the case, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_is_div) begin
                        state_d = b_is_zero ? S_DONE : S_DIV;
                    end else if (cmd_op == OP_ILLEGAL) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: state_d = S_DONE;
            S_DIV: begin
                if (div_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: state_d = S_DONE;
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One restoring step: the trial subtraction's sign bit says whether the divisor fits.
    always_comb begin
        rem_shift = {1'b0, rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
        if (rem_q[DATA_W-1]) begin
            rem_shift = {rem_q, quo_q[DATA_W-1]};
        end
        rem_trial = rem_shift - {1'b0, dvs_q};
        take      = ~rem_trial[DATA_W];
    end

    always_comb begin
        exec_result = alu_result;
        case (op_q)
            OP_ONES:  exec_result = '1;
            OP_CLEAR: exec_result = '0;
            OP_NOP:   exec_result = acc_q;
            default:  exec_result = alu_result;
        endcase
    end

    // Quotient is negated when operand signs differ; remainder follows the dividend's sign.
    always_comb begin
        quo_ext    = {{EXT_W{1'b0}}, quo_q};
        rem_ext    = {{EXT_W{1'b0}}, rem_q};
        quo_signed = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? (~quo_ext + RES_W'(1)) : quo_ext;
        rem_signed = a_q[DATA_W-1] ? (~rem_ext + RES_W'(1)) : rem_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_ADD;
            err_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        a_q   <= cmd_data;
                        b_q   <= acc_q[DATA_W-1:0];
                        op_q  <= op_t'(cmd_op);
                        quo_q <= magnitude(cmd_data);
                        dvs_q <= magnitude(acc_q[DATA_W-1:0]);
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (cmd_is_div && b_is_zero) begin
                            err_q <= 2'b10;
                        end else if (cmd_op == OP_ILLEGAL) begin
                            err_q <= 2'b11;
                        end else begin
                            err_q <= 2'b00;
                        end
                    end
                end
                S_EXEC: begin
                    acc_q <= exec_result;
                    err_q <= {1'b0, ovf_err};
                end
                S_DIV: begin
                    quo_q <= {quo_q[DATA_W-2:0], take};
                    rem_q <= take ? rem_trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_FIX: begin
                    acc_q <= (op_q == OP_MOD) ? rem_signed : quo_signed;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
